// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage handshake bundle: redirect, imem request/response, decode output
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    modport master (
        input  redirect_valid, redirect_pc, id_ready,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output imem_req_valid, imem_addr,
        output if_valid, if_pc, if_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, id_ready,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  imem_req_valid, imem_addr,
        input  if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC, single outstanding imem request, valid/ready output register
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    typedef enum logic [0:0] {S_REQ, S_WAIT} state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_pc, w_pc_n;
    logic [31:0] r_req_pc, w_req_pc_n;
    logic        r_kill, w_kill_n;
    logic        r_hold_valid, w_hold_valid_n;
    logic [31:0] r_hold_pc, w_hold_pc_n;
    logic [31:0] r_hold_instr, w_hold_instr_n;
    logic        r_if_valid, w_if_valid_n;
    logic [31:0] r_if_pc, w_if_pc_n;
    logic [31:0] r_if_instr, w_if_instr_n;

    logic w_req_valid;
    logic w_accept;
    logic w_out_xfer;
    logic w_out_free;

    // No new request while the hold buffer is occupied bounds buffering to two entries.
    assign w_req_valid = rst_n && (r_state == S_REQ) && !r_hold_valid;
    assign w_accept    = w_req_valid && bus.imem_req_ready;
    assign w_out_xfer  = r_if_valid && bus.id_ready;
    assign w_out_free  = !r_if_valid || bus.id_ready;

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = r_pc;
    assign bus.if_valid       = r_if_valid;
    assign bus.if_pc          = r_if_pc;
    assign bus.if_instr       = r_if_instr;

    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_req_pc_n     = r_req_pc;
        w_kill_n       = r_kill;
        w_hold_valid_n = r_hold_valid;
        w_hold_pc_n    = r_hold_pc;
        w_hold_instr_n = r_hold_instr;
        w_if_valid_n   = r_if_valid;
        w_if_pc_n      = r_if_pc;
        w_if_instr_n   = r_if_instr;

        if (w_out_xfer) begin
            w_if_valid_n = 1'b0;
        end

        if (r_hold_valid && w_out_free) begin
            w_if_valid_n   = 1'b1;
            w_if_pc_n      = r_hold_pc;
            w_if_instr_n   = r_hold_instr;
            w_hold_valid_n = 1'b0;
        end

        case (r_state)
            S_REQ: begin
                if (w_accept) begin
                    w_req_pc_n = r_pc;
                    w_pc_n     = r_pc + 32'd4;
                    w_state_n  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    w_state_n = S_REQ;
                    if (r_kill) begin
                        w_kill_n = 1'b0;
                    end else if (w_out_free) begin
                        w_if_valid_n = 1'b1;
                        w_if_pc_n    = r_req_pc;
                        w_if_instr_n = bus.imem_rsp_data;
                    end else begin
                        w_hold_valid_n = 1'b1;
                        w_hold_pc_n    = r_req_pc;
                        w_hold_instr_n = bus.imem_rsp_data;
                    end
                end
            end
            default: w_state_n = S_REQ;
        endcase

        // A redirect flushes everything younger; a response still in flight is marked for discard.
        if (bus.redirect_valid) begin
            w_pc_n         = {bus.redirect_pc[31:2], 2'b00};
            w_if_valid_n   = 1'b0;
            w_hold_valid_n = 1'b0;
            if (((r_state == S_WAIT) && !bus.imem_rsp_valid) || w_accept) begin
                w_kill_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_req_pc     <= 32'h0;
            r_kill       <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_pc    <= 32'h0;
            r_hold_instr <= 32'h0;
            r_if_valid   <= 1'b0;
            r_if_pc      <= 32'h0;
            r_if_instr   <= 32'h0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_req_pc     <= w_req_pc_n;
            r_kill       <= w_kill_n;
            r_hold_valid <= w_hold_valid_n;
            r_hold_pc    <= w_hold_pc_n;
            r_hold_instr <= w_hold_instr_n;
            r_if_valid   <= w_if_valid_n;
            r_if_pc      <= w_if_pc_n;
            r_if_instr   <= w_if_instr_n;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a latency-programmable instruction memory
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];

    int          lat   = 1;
    logic        pend  = 1'b0;
    int          pcnt  = 0;
    logic [31:0] paddr = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, update memory after it, return at negedge.
    task automatic cyc();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        a   = bus.imem_addr;
        if (acc) q_addr.push_back(a);
        if (bus.if_valid && bus.id_ready) begin
            q_pc.push_back(bus.if_pc);
            q_ins.push_back(bus.if_instr);
        end
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = instr_of(paddr);
                pend = 1'b0;
            end
        end
        if (acc) begin
            if (lat == 1) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = instr_of(a);
            end else begin
                pend  = 1'b1;
                pcnt  = lat - 1;
                paddr = a;
            end
        end
        @(negedge clk);
    endtask

    logic [31:0] exp_addr[13] = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h108, 32'h200,
                                  32'h204, 32'h300, 32'h304, 32'hFFFF_FFFC, 32'h0, 32'h0};
    logic [31:0] exp_pc[7]    = '{32'h0, 32'h4, 32'h100, 32'h104, 32'h200, 32'h300, 32'hFFFF_FFFC};

    initial begin
        int n;
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        chk("rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        rst_n = 1'b1;

        // sequential fetch, 1-cycle memory
        cyc();
        chk("wait_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
        cyc();
        chk("seq0_valid", {31'h0, bus.if_valid}, 32'h1);
        chk("seq0_pc", bus.if_pc, 32'h0);
        chk("seq0_instr", bus.if_instr, instr_of(32'h0));
        chk("seq_addr4", bus.imem_addr, 32'h4);
        cyc();
        cyc();
        chk("seq4_pc", bus.if_pc, 32'h4);

        // redirect while waiting on a slow response for 0x8
        lat = 3;
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        cyc();
        chk("rd_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
        chk("rd_if_valid", {31'h0, bus.if_valid}, 32'h0);
        cyc();
        cyc();
        chk("rd_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        chk("rd_addr", bus.imem_addr, 32'h100);
        chk("rd_drop8", {31'h0, bus.if_valid}, 32'h0);
        lat = 1;
        cyc();
        cyc();
        chk("rd_tgt_valid", {31'h0, bus.if_valid}, 32'h1);
        chk("rd_tgt_pc", bus.if_pc, 32'h100);
        chk("rd_tgt_instr", bus.if_instr, instr_of(32'h100));

        // decode stall: one in output, one in hold, no requests
        bus.id_ready = 1'b0;
        cyc();
        n = q_addr.size();
        repeat (5) begin
            cyc();
            chk("stall_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
            chk("stall_pc", bus.if_pc, 32'h100);
        end
        chk("stall_acc", q_addr.size(), n);
        bus.id_ready = 1'b1;
        cyc();
        chk("unstall_valid", {31'h0, bus.if_valid}, 32'h1);
        chk("unstall_pc", bus.if_pc, 32'h104);
        chk("unstall_instr", bus.if_instr, instr_of(32'h104));
        chk("unstall_req", {31'h0, bus.imem_req_valid}, 32'h1);

        // redirect in the accept cycle of 0x108 while output holds 0x104
        lat = 3;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        cyc();
        chk("acc_rd_if_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("acc_rd_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
        cyc();
        cyc();
        cyc();
        chk("acc_rd_addr", bus.imem_addr, 32'h200);
        chk("acc_rd_drop", {31'h0, bus.if_valid}, 32'h0);
        lat = 1;
        cyc();
        cyc();
        chk("acc_rd_tgt_pc", bus.if_pc, 32'h200);

        // redirect coinciding with the response for 0x204
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h302;
        cyc();
        chk("co_rd_if_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("co_rd_req", {31'h0, bus.imem_req_valid}, 32'h1);
        chk("co_rd_addr", bus.imem_addr, 32'h300);
        cyc();
        cyc();
        chk("co_rd_nokill_valid", {31'h0, bus.if_valid}, 32'h1);
        chk("co_rd_nokill_pc", bus.if_pc, 32'h300);

        // PC wrap at the top of the address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        cyc();
        cyc();
        chk("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        cyc();
        cyc();
        chk("wrap_pc", bus.if_pc, 32'hFFFF_FFFC);
        chk("wrap_addr0", bus.imem_addr, 32'h0);

        // reset in the middle of a slow fetch
        lat = 3;
        cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, bus.imem_req_valid}, 32'h0);
        chk("mid_rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("mid_rst_if_pc", bus.if_pc, 32'h0);
        chk("mid_rst_if_instr", bus.if_instr, 32'h0);
        chk("mid_rst_addr", bus.imem_addr, 32'h0);
        pend = 1'b0;
        lat  = 1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("post_rst_valid", {31'h0, bus.if_valid}, 32'h1);
        chk("post_rst_pc", bus.if_pc, 32'h0);

        chk("n_addr", q_addr.size(), 13);
        for (int i = 0; i < 13; i++)
            chk("addr_seq", (i < q_addr.size()) ? q_addr[i] : 32'hDEAD_BEEF, exp_addr[i]);
        chk("n_xfer", q_pc.size(), 7);
        for (int i = 0; i < 7; i++) begin
            chk("xfer_pc", (i < q_pc.size()) ? q_pc[i] : 32'hDEAD_BEEF, exp_pc[i]);
            chk("xfer_instr", (i < q_ins.size()) ? q_ins[i] : 32'hDEAD_BEEF, instr_of(exp_pc[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the RV32I core: owns the PC, issues one instruction-memory request at a time, and presents the fetched {pc, instr} to decode through a valid/ready output register.
- Sits directly downstream of the branch unit. The execute stage combines branch_taken, the branch target and jumps into redirect_valid/redirect_pc, which this block consumes to steer the PC and flush in-flight fetches.
- Fetches sequentially (pc+4) otherwise.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  taken branch/jump from execute; single-cycle pulse.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0).
- id_ready  input  1  decode accepts the output register this cycle.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_addr  output  32  fetch address (word aligned).
- imem_rsp_valid  input  1  response valid; exactly one response per accepted request, at least 1 cycle later, not back-pressurable.
- imem_rsp_data  input  32  instruction word.
- if_valid  output  1  output register holds a valid instruction.
- if_pc  output  32  PC of if_instr.
- if_instr  output  32  fetched instruction.

Behaviour:
- Clock/reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: pc=RESET_PC, state=REQ, kill=0, hold_valid=0, if_valid=0, if_pc=0, if_instr=0. imem_req_valid=0 while rst_n low.
- Combinational outputs: imem_req_valid=(state==REQ) && !hold_valid; imem_addr=pc. Neither depends combinationally on redirect_valid.
- Handshakes: request accepted when imem_req_valid && imem_req_ready. Output transfer when if_valid && id_ready.
- State REQ:
  - On accept: req_pc<=pc; pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); go WAIT.
  - If redirect_valid in the same cycle as accept: pc<=redirect_pc, kill<=1.
- State WAIT, on imem_rsp_valid:
  - kill=1: discard the data, kill<=0, go REQ.
  - Otherwise, if output register is empty or transferring this cycle: if_valid<=1, if_pc<=req_pc, if_instr<=data.
  - Otherwise: capture into the one-entry hold buffer (hold_valid<=1). Go REQ either way.
  - If redirect_valid coincides with rsp_valid: the response is discarded; kill is not set.
- Hold buffer: when the output register is empty or transferring and hold_valid=1, the buffer moves into the output register and hold_valid<=0. No new request is issued while hold_valid=1, so at most one instruction is in the hold buffer and one in the output register.
- Redirect (any state): takes priority over all other updates.
  - pc<=redirect_pc & ~3; if_valid<=0; hold_valid<=0.
  - If a request is outstanding (WAIT, no coinciding rsp), or accepted this cycle: kill<=1.
  - Decode never sees an instruction fetched before the redirect.
- Redirect latency: first request to the target is issued the cycle after redirect if nothing is outstanding. Otherwise it is issued the cycle after the killed response returns.
- No-stall latency: output if_valid is 1 cycle after imem_rsp_valid. Sustained throughput is 1 instruction per 2 cycles with 1-cycle memory (single outstanding request).
- Reset mid-operation: all state returns to reset values immediately. A response arriving in the first post-reset cycles for a pre-reset request is not expected; the memory is reset by the same rst_n.
- The output register holds if_pc/if_instr stable while if_valid && !id_ready.

Test Plan:
- Reset release, 1-cycle memory always ready, id_ready=1 -> imem_addr sequence 0x0,0x4,0x8; if_pc/if_instr match, each if_valid 1 cycle after rsp.
- Redirect to 0x0000_0103 while WAIT for 0x8 -> response for 0x8 dropped; next imem_addr=0x100; if_valid never shows pc 0x8.
- id_ready=0 for 6 cycles after first instr -> at most 2 instructions buffered, no request issued while hold_valid=1, if_pc stable; releasing id_ready delivers 0x0 then 0x4 in order, no loss or duplication.
- Redirect same cycle as request accept for 0xC, with if_valid=1 -> if_valid=0 next cycle; response for 0xC dropped; next fetch at target.
- Redirect coinciding with rsp_valid -> that response dropped; kill stays 0; target fetched the next cycle.
- PC at 0xFFFF_FFFC -> next imem_addr=0x0000_0000; assert rst_n low mid-WAIT -> all outputs zero immediately, refetch from RESET_PC.
